wb_data_upsizer: RTL and testbench

Wishbone B3 data-width upsizer bridging a narrow master (DW_IN bits) onto a wide slave (DW_IN*SCALE bits) with a shared byte address space. Narrow writes become single wide writes with lane-shifted select. Narrow reads are served from a one-line wide read buffer when possible, otherwise fetched as one full wide word. Sits between a CPU/BFM master and a wide memory or interconnect port.

---
 rtl/wb_upsizer_pkg.sv | 36 +++
 rtl/wb_upsizer_rdbuf.sv | 47 ++++
 rtl/wb_data_upsizer.sv | 133 +++++++++++++
 tb/tb_wb_data_upsizer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_upsizer_pkg.sv
// Shared widths, lane helpers and Wishbone cycle-type constants for the data upsizer.
package wb_upsizer_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Lane helpers work on a generous fixed width; callers cast to their real widths.
    localparam int unsigned LANE_MAX_W = 1024;

    function automatic int unsigned lb_of(input int unsigned dw_in);
        return $clog2(dw_in / 8);
    endfunction

    function automatic int unsigned ls_of(input int unsigned scale);
        return $clog2(scale);
    endfunction

    function automatic int unsigned dw_out_of(input int unsigned dw_in, input int unsigned scale);
        return dw_in * scale;
    endfunction

    function automatic logic [LANE_MAX_W-1:0] lane_extract(input logic [LANE_MAX_W-1:0] word,
                                                           input int unsigned lane,
                                                           input int unsigned lane_w);
        return word >> (lane * lane_w);
    endfunction

    function automatic logic [LANE_MAX_W-1:0] lane_shift(input logic [LANE_MAX_W-1:0] word,
                                                         input int unsigned lane,
                                                         input int unsigned lane_w);
        return word << (lane * lane_w);
    endfunction

endpackage

// File: rtl/wb_upsizer_rdbuf.sv
// One-line wide read buffer: fill, invalidate, tag compare and narrow lane read-out.
module wb_upsizer_rdbuf
    import wb_upsizer_pkg::*;
#(
    parameter int unsigned DW  = 64,
    parameter int unsigned TW  = 29,
    parameter int unsigned LW  = 32,
    parameter int unsigned LSW = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           fill,
    input  logic           inval,
    input  logic [DW-1:0]  fill_data,
    input  logic [TW-1:0]  fill_tag,
    input  logic [TW-1:0]  look_tag,
    input  logic [LSW-1:0] lane,
    output logic           hit_c,
    output logic [LW-1:0]  lane_data_c
);

    logic [DW-1:0] buf_data;
    logic [TW-1:0] buf_tag;
    logic          buf_valid;

    // Invalidate has priority so a fill racing a bus-cycle end leaves the line invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
        end else if (inval) begin
            buf_valid <= 1'b0;
        end else if (fill) begin
            buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            buf_data <= fill_data;
            buf_tag  <= fill_tag;
        end
    end

    assign hit_c       = buf_valid && (buf_tag == look_tag);
    assign lane_data_c = LW'(lane_extract(LANE_MAX_W'(buf_data), 32'(lane), LW));

endmodule

// File: rtl/wb_data_upsizer.sv
// Wishbone narrow-to-wide data upsizer: combinational request/response steering around a read buffer.
module wb_data_upsizer
    import wb_upsizer_pkg::*;
#(
    parameter int unsigned DW_IN = 32,
    parameter int unsigned SCALE = 2,
    parameter int unsigned AW    = 32
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic [AW-1:0]                   wbs_adr_i,
    input  logic [DW_IN-1:0]                wbs_dat_i,
    input  logic [DW_IN/8-1:0]              wbs_sel_i,
    input  logic                            wbs_we_i,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_stb_i,
    input  logic [2:0]                      wbs_cti_i,
    input  logic [1:0]                      wbs_bte_i,
    output logic [DW_IN-1:0]                wbs_dat_o,
    output logic                            wbs_ack_o,
    output logic                            wbs_err_o,
    output logic                            wbs_rty_o,
    output logic [AW-1:0]                   wbm_adr_o,
    output logic [DW_IN*SCALE-1:0]          wbm_dat_o,
    output logic [DW_IN*SCALE/8-1:0]        wbm_sel_o,
    output logic                            wbm_we_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [DW_IN*SCALE-1:0]          wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    input  logic                            wbm_rty_i
);

    localparam int unsigned DW_OUT = dw_out_of(DW_IN, SCALE);
    localparam int unsigned LB     = lb_of(DW_IN);
    localparam int unsigned LS     = ls_of(SCALE);
    localparam int unsigned OFF    = LB + LS;
    localparam int unsigned TW     = AW - OFF;
    localparam int unsigned SW     = DW_IN / 8;
    localparam int unsigned SWO    = DW_OUT / 8;

    logic              rst_n;
    logic [LS-1:0]     lane;
    logic [TW-1:0]     tag;
    logic              req;
    logic              wr_req;
    logic              rd_miss;
    logic              rd_hit;
    logic              hit_c;
    logic              fill;
    logic              inval;
    logic [DW_IN-1:0]  buf_lane;
    logic [DW_IN-1:0]  wide_lane;
    logic [SWO-1:0]    wr_sel;
    logic              unused_bits;

    assign rst_n       = wb_rst_i;
    assign lane        = wbs_adr_i[OFF-1:LB];
    assign tag         = wbs_adr_i[AW-1:OFF];
    // Narrow cti/bte and sub-word address bits carry no meaning for the wide side.
    assign unused_bits = ^{wbs_cti_i, wbs_bte_i, wbs_adr_i};

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign wr_req  = req & wbs_we_i;
    assign rd_hit  = req & ~wbs_we_i & hit_c;
    assign rd_miss = req & ~wbs_we_i & ~hit_c;

    assign fill  = rd_miss & wbm_ack_i;
    assign inval = ~wbs_cyc_i | (wr_req & (wbm_ack_i | wbm_err_i | wbm_rty_i));

    assign wr_sel    = SWO'(lane_shift(LANE_MAX_W'(wbs_sel_i), 32'(lane), SW));
    assign wide_lane = DW_IN'(lane_extract(LANE_MAX_W'(wbm_dat_i), 32'(lane), DW_IN));

    assign wbm_adr_o = {tag, {OFF{1'b0}}};
    assign wbm_dat_o = {SCALE{wbs_dat_i}};
    assign wbm_cti_o = CTI_CLASSIC;
    assign wbm_bte_o = BTE_LINEAR;

    wb_upsizer_rdbuf #(
        .DW  (DW_OUT),
        .TW  (TW),
        .LW  (DW_IN),
        .LSW (LS)
    ) u_rdbuf (
        .clk         (wb_clk_i),
        .rst_n       (rst_n),
        .fill        (fill),
        .inval       (inval),
        .fill_data   (wbm_dat_i),
        .fill_tag    (tag),
        .look_tag    (tag),
        .lane        (lane),
        .hit_c       (hit_c),
        .lane_data_c (buf_lane)
    );

    // Steering: hits answer locally, writes and misses pass straight through to the wide slave.
    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = '0;
        wbs_ack_o = 1'b0;
        wbs_err_o = 1'b0;
        wbs_rty_o = 1'b0;
        wbs_dat_o = buf_lane;
        if (rst_n) begin
            if (wr_req) begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_sel_o = wr_sel;
                wbs_ack_o = wbm_ack_i;
                wbs_err_o = wbm_err_i;
                wbs_rty_o = wbm_rty_i;
            end else if (rd_miss) begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_sel_o = '1;
                wbs_ack_o = wbm_ack_i;
                wbs_err_o = wbm_err_i;
                wbs_rty_o = wbm_rty_i;
                wbs_dat_o = wide_lane;
            end else if (rd_hit) begin
                wbs_ack_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_data_upsizer.sv
// Scoreboard bench for wb_data_upsizer: driver pushes expected responses, negedge monitor checks them.
module tb_wb_data_upsizer;
    import wb_upsizer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic [31:0] wbm_adr_o;
    logic [63:0] wbm_dat_o;
    logic [7:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [63:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

    always #5 clk = ~clk;

    wb_data_upsizer #(.DW_IN(32), .SCALE(2), .AW(32)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i)
    );

    typedef struct {
        int          id;
        bit          err;
        bit          rd;
        bit          wide;
        logic [31:0] adr;
        logic [7:0]  sel;
        logic [63:0] wdat;
        logic [31:0] rdat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] smem [logic [31:0]];
    logic [31:0] refm [0:255];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_issued = 0;
    int          n_resp = 0;

    function automatic exp_t mk(input int id, input bit err, input bit rd, input bit wide,
                                input logic [31:0] adr, input logic [7:0] sel,
                                input logic [63:0] wdat, input logic [31:0] rdat);
        exp_t e;
        e.id = id; e.err = err; e.rd = rd; e.wide = wide;
        e.adr = adr; e.sel = sel; e.wdat = wdat; e.rdat = rdat;
        return e;
    endfunction

    task automatic chk(input int id, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL id=%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rd_mem(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : 64'h0;
    endfunction

    // Wide-slave memory update honouring byte selects.
    task automatic wr_mem(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] m;
        m = rd_mem(a);
        for (int b = 0; b < 8; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
        smem[a] = m;
    endtask

    // Monitor: every narrow-side response consumes one scoreboard entry.
    always @(negedge clk) begin
        if (wbs_ack_o | wbs_err_o | wbs_rty_o) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_response: got ack=%b err=%b expected none", wbs_ack_o, wbs_err_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk(mon_e.id, "resp_kind", 64'({wbs_err_o, wbs_ack_o, wbs_rty_o}),
                    mon_e.err ? 64'b100 : 64'b010);
                chk(mon_e.id, "wbm_cyc", 64'(wbm_cyc_o), 64'(mon_e.wide));
                if (mon_e.wide) begin
                    chk(mon_e.id, "wbm_adr", 64'(wbm_adr_o), 64'(mon_e.adr));
                    chk(mon_e.id, "wbm_sel", 64'(wbm_sel_o), 64'(mon_e.sel));
                    chk(mon_e.id, "wbm_we", 64'(wbm_we_o), 64'(!mon_e.rd));
                    if (!mon_e.rd) chk(mon_e.id, "wbm_dat", wbm_dat_o, mon_e.wdat);
                end
                if (mon_e.rd && !mon_e.err) chk(mon_e.id, "rd_data", 64'(wbs_dat_o), 64'(mon_e.rdat));
            end
        end
    end

    // Drives one narrow beat and plays the wide slave; entered and left at posedge+1.
    task automatic xfer(input exp_t e, input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [2:0] cti, input int lat,
                        input bit inj_err, input bit keep);
        wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat; wbs_sel_i = sel;
        wbs_cti_i = cti; wbs_bte_i = 2'b00; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        exp_q.push_back(e);
        n_issued++;
        #1;
        if (wbm_stb_o) begin
            repeat (lat) begin @(posedge clk); #1; end
            wbm_dat_i = rd_mem(wbm_adr_o);
            if (inj_err) wbm_err_i = 1'b1;
            else begin
                wbm_ack_i = 1'b1;
                if (wbm_we_o) wr_mem(wbm_adr_o, wbm_dat_o, wbm_sel_o);
            end
            @(posedge clk); #1;
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        end else begin
            if (!wbs_ack_o) begin
                n_cmp++; n_bad++;
                $display("FAIL id=%0d no_response: got neither ack nor wide strobe expected one", e.id);
            end
            @(posedge clk); #1;
        end
        if (!keep) begin
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        logic [7:0]  ws;
        logic        ln;

        smem[32'h08] = 64'hCAFEF00D_0BADBEEF;
        smem[32'h10] = 64'h11112222_33334444;
        smem[32'h20] = 64'h55556666_77778888;
        smem[32'h30] = 64'h9999AAAA_BBBBCCCC;
        for (int i = 0; i < 256; i++) refm[i] = 32'h0;

        // Reset held with an active request and a stray slave ack: nothing may leak through.
        rst_n = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h8; wbs_dat_i = '0; wbs_sel_i = 4'hF; wbs_cti_i = CTI_CLASSIC; wbs_bte_i = '0;
        wbm_dat_i = '0; wbm_ack_i = 1'b1; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(0, "reset_wbm_cyc", 64'(wbm_cyc_o), 64'd0);
        chk(0, "reset_wbm_stb", 64'(wbm_stb_o), 64'd0);
        chk(0, "reset_wbs_ack", 64'(wbs_ack_o), 64'd0);
        wbm_ack_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(mk(1, 0, 1, 1, 32'h8, 8'hFF, 64'h0, 32'h0BADBEEF), 32'h8, 0, 0, 4'hF, CTI_CLASSIC, 1, 0, 0);
        xfer(mk(2, 0, 0, 1, 32'h8, 8'hF0, 64'hDEADBEEF_DEADBEEF, 0), 32'hC, 1, 32'hDEADBEEF, 4'hF, CTI_CLASSIC, 2, 0, 0);
        xfer(mk(3, 0, 1, 1, 32'h8, 8'hFF, 64'h0, 32'hDEADBEEF), 32'hC, 0, 0, 4'hF, CTI_INC, 0, 0, 1);
        xfer(mk(4, 0, 1, 0, 32'h0, 8'h00, 64'h0, 32'h0BADBEEF), 32'h8, 0, 0, 4'hF, CTI_EOB, 0, 0, 0);

        xfer(mk(5, 0, 1, 1, 32'h10, 8'hFF, 64'h0, 32'h33334444), 32'h10, 0, 0, 4'hF, CTI_INC, 2, 0, 1);
        xfer(mk(6, 0, 1, 0, 32'h0, 8'h00, 64'h0, 32'h11112222), 32'h14, 0, 0, 4'hF, CTI_INC, 0, 0, 1);
        xfer(mk(7, 0, 0, 1, 32'h10, 8'hF0, 64'hA5A5A5A5_A5A5A5A5, 0), 32'h14, 1, 32'hA5A5A5A5, 4'hF, CTI_CLASSIC, 0, 0, 1);
        xfer(mk(8, 0, 1, 1, 32'h10, 8'hFF, 64'h0, 32'hA5A5A5A5), 32'h14, 0, 0, 4'hF, CTI_CLASSIC, 1, 0, 1);
        xfer(mk(9, 0, 1, 0, 32'h0, 8'h00, 64'h0, 32'h33334444), 32'h10, 0, 0, 4'hF, CTI_EOB, 0, 0, 0);

        xfer(mk(10, 1, 1, 1, 32'h20, 8'hFF, 64'h0, 0), 32'h20, 0, 0, 4'hF, CTI_CLASSIC, 1, 1, 1);
        xfer(mk(11, 0, 1, 1, 32'h20, 8'hFF, 64'h0, 32'h77778888), 32'h20, 0, 0, 4'hF, CTI_CLASSIC, 0, 0, 1);
        xfer(mk(12, 0, 1, 0, 32'h0, 8'h00, 64'h0, 32'h55556666), 32'h24, 0, 0, 4'hF, CTI_CLASSIC, 0, 0, 0);

        xfer(mk(13, 0, 1, 1, 32'h30, 8'hFF, 64'h0, 32'hBBBBCCCC), 32'h30, 0, 0, 4'hF, CTI_CLASSIC, 0, 0, 0);
        xfer(mk(14, 0, 1, 1, 32'h30, 8'hFF, 64'h0, 32'h9999AAAA), 32'h34, 0, 0, 4'hF, CTI_CLASSIC, 0, 0, 0);

        // Fill inside an open bus cycle, then reset mid-cycle: the line must not survive.
        xfer(mk(15, 0, 1, 1, 32'h10, 8'hFF, 64'h0, 32'h33334444), 32'h10, 0, 0, 4'hF, CTI_CLASSIC, 0, 0, 1);
        wbs_stb_i = 1'b0;
        #2;
        rst_n = 1'b0; wbs_stb_i = 1'b1; wbs_adr_i = 32'h14; wbs_we_i = 1'b0; wbm_ack_i = 1'b1;
        #1;
        chk(16, "midreset_wbm_cyc", 64'(wbm_cyc_o), 64'd0);
        chk(16, "midreset_wbs_ack", 64'(wbs_ack_o), 64'd0);
        @(posedge clk); #1;
        wbm_ack_i = 1'b0; wbs_stb_i = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(mk(17, 0, 1, 1, 32'h10, 8'hFF, 64'h0, 32'hA5A5A5A5), 32'h14, 0, 0, 4'hF, CTI_CLASSIC, 0, 0, 0);

        // Bulk traffic: random-select writes, then paired burst reads (miss then same-line hit).
        for (int i = 0; i < 256; i++) begin
            a  = 32'h1000 + 32'(i) * 4;
            d  = $urandom;
            s  = 4'($urandom_range(1, 15));
            ln = a[2];
            ws = ln ? {s, 4'h0} : {4'h0, s};
            for (int b = 0; b < 4; b++) if (s[b]) refm[i][b*8 +: 8] = d[b*8 +: 8];
            xfer(mk(1000 + i, 0, 0, 1, {a[31:3], 3'b000}, ws, {d, d}, 0), a, 1, d, s,
                 (i % 3 == 0) ? CTI_INC : CTI_CLASSIC, $urandom_range(0, 2), 0, (i % 4) != 3);
        end
        for (int i = 0; i < 256; i += 2) begin
            a = 32'h1000 + 32'(i) * 4;
            xfer(mk(2000 + i, 0, 1, 1, a, 8'hFF, 64'h0, refm[i]), a, 0, 0, 4'hF, CTI_INC,
                 $urandom_range(0, 2), 0, 1);
            xfer(mk(2001 + i, 0, 1, 0, 32'h0, 8'h00, 64'h0, refm[i+1]), a + 4, 0, 0, 4'hF, CTI_EOB,
                 0, 0, 0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk(9000, "queue_drained", 64'(exp_q.size()), 64'd0);
        chk(9001, "response_count", 64'(n_resp), 64'(n_issued));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
